// File: rtl/phy_rx_pkg.sv
// ============================================================================
//  Module   : phy_rx_pkg
//  Brief    : Shared constants and width helpers for the PHY receive path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package phy_rx_pkg;

    // Comma symbol used by the upstream serial-to-parallel aligner
    localparam logic [7:0] c_com_symbol = 8'hBC;

    function automatic int calc_word_w(input int byte_w, input int bytes_per_word);
        return byte_w * bytes_per_word;
    endfunction

    // Index width that stays at least one bit for single-entry ranges
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phy_rx_lane_fifo.sv
// ============================================================================
//  Module   : phy_rx_lane_fifo
//  Brief    : Per-lane synchronous skew FIFO with wrap-bit full/empty flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    assign o_rdata = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/phy_rx_unstripe_n.sv
// ============================================================================
//  Module   : phy_rx_unstripe_n
//  Brief    : N-lane receive merger: per-lane word assembly, skew FIFOs and
//             strict round-robin un-striping with output backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_rx_unstripe_n
    import phy_rx_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int c_word_w      = calc_word_w(BYTE_W, BYTES_PER_WORD),
    localparam int c_cfg_w       = $clog2(LANES + 1)
) (
    input  logic                      clk_4f,
    input  logic                      reset,
    input  logic [LANES*BYTE_W-1:0]   data_in,
    input  logic [LANES-1:0]          valid_in,
    input  logic [LANES-1:0]          lane_active,
    input  logic [c_cfg_w-1:0]        cfg_lanes,
    input  logic                      out_ready,
    output logic [c_word_w-1:0]       data_out,
    output logic                      valid_out,
    output logic [LANES-1:0]          overflow
);

    localparam int c_lane_w = idx_w(LANES);
    localparam int c_cnt_w  = idx_w(BYTES_PER_WORD);

    logic [c_cfg_w-1:0]  r_nlanes;
    logic [c_cfg_w-1:0]  w_cfg_clamped;
    logic [c_lane_w-1:0] r_rr_ptr;
    logic [c_lane_w-1:0] w_rr_next;
    logic [c_word_w-1:0] r_data_out;
    logic                r_valid_out;
    logic [LANES-1:0]    r_overflow;

    logic [LANES-1:0]    w_push;
    logic [LANES-1:0]    w_pop;
    logic [LANES-1:0]    w_full;
    logic [LANES-1:0]    w_empty;
    logic [LANES-1:0]    w_ovf_set;
    logic [LANES-1:0]    w_cnt_zero;
    logic [c_word_w-1:0] w_fifo_rdata [LANES];
    logic                w_load;
    logic                w_idle;

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign overflow  = r_overflow;

    always_comb begin
        w_cfg_clamped = cfg_lanes;
        if (cfg_lanes == '0) begin
            w_cfg_clamped = c_cfg_w'(1);
        end else if (cfg_lanes > c_cfg_w'(LANES)) begin
            w_cfg_clamped = c_cfg_w'(LANES);
        end
    end

    // Strict ordering: an empty head lane stalls the merge rather than being skipped
    assign w_load    = (!r_valid_out || out_ready) && !w_empty[r_rr_ptr];
    assign w_rr_next = (r_rr_ptr == c_lane_w'(r_nlanes - 1'b1)) ? '0 : r_rr_ptr + 1'b1;
    assign w_idle    = (&w_empty) && (&w_cnt_zero) && !r_valid_out;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [c_cfg_w-1:0]  c_lane_num = c_cfg_w'(k);
        localparam logic [c_lane_w-1:0] c_lane_idx = c_lane_w'(k);

        logic [c_cnt_w-1:0]  r_cnt;
        logic [c_word_w-1:0] r_word;
        logic [c_word_w-1:0] w_word;
        logic                w_en;
        logic                w_take;
        logic                w_last;

        assign w_en   = (c_lane_num < r_nlanes);
        assign w_take = w_en && valid_in[k] && lane_active[k];
        assign w_last = (r_cnt == c_cnt_w'(BYTES_PER_WORD - 1));

        // Shifting in at the LSB leaves the first byte of the word in the MSBs
        assign w_word = (r_word << BYTE_W) | c_word_w'(data_in[k*BYTE_W +: BYTE_W]);

        assign w_push[k]     = w_take && w_last;
        assign w_pop[k]      = w_load && (r_rr_ptr == c_lane_idx);
        assign w_ovf_set[k]  = w_push[k] && w_full[k] && !w_pop[k];
        assign w_cnt_zero[k] = (r_cnt == '0);

        always_ff @(posedge clk_4f) begin
            if (reset) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else if (!w_en || !lane_active[k]) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_word <= w_word;
                r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            end
        end

        phy_rx_lane_fifo #(
            .WIDTH (c_word_w),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk_4f),
            .rst     (reset),
            .i_push  (w_push[k]),
            .i_wdata (w_word),
            .i_pop   (w_pop[k]),
            .o_rdata (w_fifo_rdata[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_rr_ptr    <= '0;
            r_nlanes    <= w_cfg_clamped;
            r_overflow  <= '0;
        end else begin
            r_overflow <= r_overflow | w_ovf_set;
            if (w_load) begin
                r_data_out  <= w_fifo_rdata[r_rr_ptr];
                r_valid_out <= 1'b1;
                r_rr_ptr    <= w_rr_next;
            end else if (out_ready) begin
                r_valid_out <= 1'b0;
            end
            // Lane count only changes when nothing is in flight anywhere
            if (w_idle) begin
                r_nlanes <= w_cfg_clamped;
                r_rr_ptr <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_unstripe_n.sv
// ============================================================================
//  Module   : tb_phy_rx_unstripe_n
//  Brief    : Directed self-checking bench for the N-lane receive merger.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phy_rx_unstripe_n;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [1:0]  valid_in;
    logic [1:0]  lane_active;
    logic [1:0]  cfg_lanes;
    logic        out_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic [1:0]  overflow;

    always #5 clk_4f = ~clk_4f;

    phy_rx_unstripe_n #(
        .LANES          (2),
        .BYTE_W         (8),
        .BYTES_PER_WORD (4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .lane_active (lane_active),
        .cfg_lanes   (cfg_lanes),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .overflow    (overflow)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  valid;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    bit          record;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic [1:0] v, input logic ev, input logic [31:0] ed);
        vec_t t;
        t.data = d;
        t.valid = v;
        t.exp_valid = ev;
        t.exp_data = ed;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk_4f);
        #1;
        if (record && valid_out && out_ready) got.push_back(data_out);
    endtask

    task automatic drive(input logic [7:0] b1, input logic [7:0] b0, input logic [1:0] v, input logic [1:0] a);
        data_in     = {b1, b0};
        valid_in    = v;
        lane_active = a;
    endtask

    task automatic idle(input int n);
        drive(8'h00, 8'h00, 2'b00, 2'b11);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic [1:0] cfg);
        reset     = 1'b1;
        cfg_lanes = cfg;
        drive(8'h00, 8'h00, 2'b00, 2'b11);
        step();
        reset = 1'b0;
    endtask

    task automatic check_got(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(name, (i < got.size()) ? got[i] : 32'hDEADDEAD, exp_q[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        record = 1'b0;
        out_ready = 1'b1;

        // Reset state
        do_reset(2'd2);
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_data", data_out, 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);

        // Aligned lanes, then lane1 skewed by three cycles
        add(16'h1101, 2'b11, 1'b0, 32'h0);
        add(16'h1202, 2'b11, 1'b0, 32'h0);
        add(16'h1303, 2'b11, 1'b0, 32'h0);
        add(16'h1404, 2'b11, 1'b0, 32'h0);
        add(16'h0000, 2'b00, 1'b1, 32'h01020304);
        add(16'h0000, 2'b00, 1'b1, 32'h11121314);
        add(16'h0000, 2'b00, 1'b0, 32'h0);
        add(16'h0021, 2'b01, 1'b0, 32'h0);
        add(16'h0022, 2'b01, 1'b0, 32'h0);
        add(16'h0023, 2'b01, 1'b0, 32'h0);
        add(16'h3124, 2'b11, 1'b0, 32'h0);
        add(16'h3200, 2'b10, 1'b1, 32'h21222324);
        add(16'h3300, 2'b10, 1'b0, 32'h0);
        add(16'h3400, 2'b10, 1'b0, 32'h0);
        add(16'h0000, 2'b00, 1'b1, 32'h31323334);
        add(16'h0000, 2'b00, 1'b0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].data[15:8], tbl[i].data[7:0], tbl[i].valid, 2'b11);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), data_out, tbl[i].exp_data);
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'h0);
        end

        // Backpressure: one lane, six words, sink stalled
        do_reset(2'd1);
        out_ready = 1'b0;
        for (int w = 1; w <= 6; w++) begin
            for (int b = 0; b < 4; b++) begin
                drive(8'h00, 8'((w << 4) | b), 2'b01, 2'b11);
                step();
            end
        end
        idle(2);
        chk("stall_valid", 32'(valid_out), 32'h1);
        chk("stall_hold", data_out, 32'h10111213);
        chk("stall_ovf", 32'(overflow), 32'h1);
        got.delete();
        exp_q = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243, 32'h50515253};
        out_ready = 1'b1;
        record = 1'b1;
        if (valid_out) got.push_back(data_out);
        idle(10);
        check_got("drain");
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Lane1 drops alignment mid-word
        do_reset(2'd2);
        got.delete();
        drive(8'hEE, 8'h41, 2'b11, 2'b11); step();
        drive(8'hEF, 8'h42, 2'b11, 2'b11); step();
        drive(8'h00, 8'h43, 2'b01, 2'b01); step();
        drive(8'h51, 8'h44, 2'b11, 2'b11); step();
        drive(8'h52, 8'h00, 2'b10, 2'b11); step();
        drive(8'h53, 8'h00, 2'b10, 2'b11); step();
        drive(8'h54, 8'h00, 2'b10, 2'b11); step();
        idle(6);
        exp_q = '{32'h41424344, 32'h51525354};
        check_got("partial_drop");

        // Lane count 2 -> 1 while idle: lane1 traffic ignored
        cfg_lanes = 2'd1;
        idle(1);
        got.delete();
        for (int b = 0; b < 8; b++) begin
            drive(8'(8'h81 + b), 8'(8'h61 + b), 2'b11, 2'b11);
            step();
        end
        idle(6);
        exp_q = '{32'h61626364, 32'h65666768};
        check_got("one_lane");

        // Lane count change while busy is deferred until drained
        got.delete();
        drive(8'h00, 8'h71, 2'b01, 2'b11); step();
        cfg_lanes = 2'd2;
        drive(8'h91, 8'h72, 2'b11, 2'b11); step();
        drive(8'h92, 8'h73, 2'b11, 2'b11); step();
        drive(8'h93, 8'h74, 2'b11, 2'b11); step();
        drive(8'h94, 8'h00, 2'b10, 2'b11); step();
        idle(6);
        exp_q = '{32'h71727374};
        check_got("busy_cfg");
        got.delete();
        for (int b = 0; b < 4; b++) begin
            drive(8'(8'hB1 + b), 8'(8'hA1 + b), 2'b11, 2'b11);
            step();
        end
        idle(6);
        exp_q = '{32'hA1A2A3A4, 32'hB1B2B3B4};
        check_got("two_lane_again");

        // Reset with buffered data and a held output word
        record = 1'b0;
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(8'(8'hD1 + b), 8'(8'hC1 + b), 2'b11, 2'b11);
            step();
        end
        idle(2);
        chk("pre_reset_valid", 32'(valid_out), 32'h1);
        do_reset(2'd2);
        chk("mid_reset_valid", 32'(valid_out), 32'h0);
        chk("mid_reset_data", data_out, 32'h0);
        chk("mid_reset_ovf", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        record = 1'b1;
        got.delete();
        idle(6);
        exp_q.delete();
        check_got("post_reset_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
